// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared types and constants for the data-memory arbiter slice:
//   state_t           - access FSM states (IDLE, ACCESS, RESP)
//   PORT_CPU/PORT_DMA - requester index values used for grant/last-grant
//   MEM_BYTES_DEFAULT - default data-memory size in bytes
//   DATA_W            - memory word width
// ---------------------------------------------------------------------------
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int MEM_BYTES_DEFAULT = 128;
   localparam int DATA_W            = 16;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the two requester ports (CPU "C_", DMA "D_") and the data-memory
// command bus.
//   slave  modport : seen by the arbiter (takes requests, drives memory)
//   master modport : seen by requesters/memory model (drives requests and
//                    MemReadData, observes Acks, RData, memory command, Err)
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if import data_mem_arb_pkg::*; #(
   parameter int ADDR_W = 16
) ();

   logic              C_Req;
   logic              C_Write;
   logic [ADDR_W-1:0] C_Addr;
   logic [DATA_W-1:0] C_WData;
   logic              C_Ack;
   logic [DATA_W-1:0] C_RData;

   logic              D_Req;
   logic              D_Write;
   logic [ADDR_W-1:0] D_Addr;
   logic [DATA_W-1:0] D_WData;
   logic              D_Ack;
   logic [DATA_W-1:0] D_RData;

   logic [ADDR_W-1:0] MemAddress;
   logic [DATA_W-1:0] MemWriteData;
   logic              MemWrite;
   logic              MemRead;
   logic [DATA_W-1:0] MemReadData;
   logic              Err;

   modport slave (
      input  C_Req, C_Write, C_Addr, C_WData,
      input  D_Req, D_Write, D_Addr, D_WData,
      input  MemReadData,
      output C_Ack, C_RData, D_Ack, D_RData,
      output MemAddress, MemWriteData, MemWrite, MemRead, Err
   );

   modport master (
      output C_Req, C_Write, C_Addr, C_WData,
      output D_Req, D_Write, D_Addr, D_WData,
      output MemReadData,
      input  C_Ack, C_RData, D_Ack, D_RData,
      input  MemAddress, MemWriteData, MemWrite, MemRead, Err
   );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin grant selection (purely combinational).
//   req_cpu, req_dma : request levels
//   last_grant       : port granted most recently
//   valid            : at least one request present
//   winner           : granted port index (PORT_CPU / PORT_DMA)
// On a tie the port that did not win last time is chosen.
// ---------------------------------------------------------------------------
module rr_arbiter_2 import data_mem_arb_pkg::*; (
   input  logic req_cpu,
   input  logic req_dma,
   input  logic last_grant,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid = req_cpu | req_dma;
      if (req_cpu && req_dma) begin
         winner = ~last_grant;
      end else if (req_dma) begin
         winner = PORT_DMA;
      end else begin
         winner = PORT_CPU;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port 16-bit data memory between a CPU and a DMA
// requester. Each access takes IDLE -> ACCESS -> RESP (3 cycles); the memory
// command is issued in ACCESS, the winner's Ack pulses in RESP.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   bus (slave)  : C_/D_ requester handshakes, memory command bus, Err
// Build option:
//   MISALIGN_CHECK_EN - when defined, an odd address skips the memory access
//                       and completes with Err=1. When undefined Err stays 0
//                       and odd addresses go to memory unchanged.
// ---------------------------------------------------------------------------
module data_mem_arbiter import data_mem_arb_pkg::*; #(
   parameter int ADDR_W    = 16,
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input logic Clock,
   input logic Reset,
   data_mem_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((1 << $clog2(MEM_BYTES)) - 1);

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_read_q, mem_read_d;
   logic              c_ack_q, c_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;

   logic              arb_valid;
   logic              arb_winner;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              misaligned;

   rr_arbiter_2 u_rr (
      .req_cpu    (bus.C_Req),
      .req_dma    (bus.D_Req),
      .last_grant (last_grant_q),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   // Request fields of whichever port the arbiter picks this cycle.
   assign sel_write = (arb_winner == PORT_DMA) ? bus.D_Write : bus.C_Write;
   assign sel_addr  = ((arb_winner == PORT_DMA) ? bus.D_Addr : bus.C_Addr) & ADDR_MASK;
   assign sel_wdata = (arb_winner == PORT_DMA) ? bus.D_WData : bus.C_WData;

`ifdef MISALIGN_CHECK_EN
   assign misaligned = sel_addr[0];
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      wr_d         = wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      c_rdata_d    = c_rdata_q;
      d_rdata_d    = d_rdata_q;
      // Strobes and Ack/Err are single-cycle pulses.
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      c_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d      = arb_winner;
               last_grant_d = arb_winner;
               wr_d         = sel_write;
               if (misaligned) begin
                  // Skip memory entirely; complete next cycle with Err.
                  state_d = RESP;
                  c_ack_d = (arb_winner == PORT_CPU);
                  d_ack_d = (arb_winner == PORT_DMA);
                  err_d   = 1'b1;
               end else begin
                  // Strobes are registered, so they are high exactly in ACCESS.
                  state_d     = ACCESS;
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = sel_wdata;
                  mem_write_d = sel_write;
                  mem_read_d  = ~sel_write;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (!wr_q) begin
               if (grant_q == PORT_CPU) c_rdata_d = bus.MemReadData;
               else                     d_rdata_d = bus.MemReadData;
            end
            c_ack_d = (grant_q == PORT_CPU);
            d_ack_d = (grant_q == PORT_DMA);
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_DMA;   // CPU wins the first tie
         grant_q      <= PORT_CPU;
         wr_q         <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         c_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         c_rdata_q    <= '0;
         d_rdata_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         wr_q         <= wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         c_ack_q      <= c_ack_d;
         d_ack_q      <= d_ack_d;
         c_rdata_q    <= c_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
      end
   end

   assign bus.C_Ack        = c_ack_q;
   assign bus.D_Ack        = d_ack_q;
   assign bus.C_RData      = c_rdata_q;
   assign bus.D_RData      = d_rdata_q;
   assign bus.MemAddress   = mem_addr_q;
   assign bus.MemWriteData = mem_wdata_q;
   assign bus.MemWrite     = mem_write_q;
   assign bus.MemRead      = mem_read_q;
   assign bus.Err          = err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a 128-byte big-endian memory model.
// Honours MISALIGN_CHECK_EN for the odd-address scenario.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 Clock = ~Clock;

   data_mem_arbiter_if #(.ADDR_W(16)) bus ();

   data_mem_arbiter #(.ADDR_W(16), .MEM_BYTES(128)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Memory model: combinational read, write on the rising edge.
   logic [7:0] mem [0:127];
   logic [6:0] a0, a1;
   assign a0 = bus.MemAddress[6:0];
   assign a1 = a0 + 7'd1;
   assign bus.MemReadData = {mem[a0], mem[a1]};

   always @(posedge Clock) begin
      if (bus.MemWrite) begin
         mem[a0] <= bus.MemWriteData[15:8];
         mem[a1] <= bus.MemWriteData[7:0];
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.C_Req = 0; bus.C_Write = 0; bus.C_Addr = '0; bus.C_WData = '0;
      bus.D_Req = 0; bus.D_Write = 0; bus.D_Addr = '0; bus.D_WData = '0;
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_c_ack", bus.C_Ack, 0);
      chk("rst_d_ack", bus.D_Ack, 0);
      chk("rst_c_rdata", bus.C_RData, 0);
      chk("rst_d_rdata", bus.D_RData, 0);
      chk("rst_memaddr", bus.MemAddress, 0);
      chk("rst_memwdata", bus.MemWriteData, 0);
      chk("rst_memwrite", bus.MemWrite, 0);
      chk("rst_memread", bus.MemRead, 0);
      chk("rst_err", bus.Err, 0);
   endtask

   task automatic test_store();
      bus.C_Req = 1; bus.C_Write = 1; bus.C_Addr = 16'h0004; bus.C_WData = 16'hBEEF;
      tick();
      chk("st_memwrite", bus.MemWrite, 1);
      chk("st_memread", bus.MemRead, 0);
      chk("st_memaddr", bus.MemAddress, 16'h0004);
      chk("st_memwdata", bus.MemWriteData, 16'hBEEF);
      chk("st_early_ack", bus.C_Ack, 0);
      tick();
      bus.C_Req = 0;
      chk("st_c_ack", bus.C_Ack, 1);
      chk("st_d_ack", bus.D_Ack, 0);
      chk("st_memwrite_resp", bus.MemWrite, 0);
      chk("st_err", bus.Err, 0);
      chk("st_mem4", mem[4], 8'hBE);
      chk("st_mem5", mem[5], 8'hEF);
      tick();
      chk("st_ack_pulse", bus.C_Ack, 0);
   endtask

   task automatic test_load();
      bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 16'h0004;
      tick();
      chk("ld_memread", bus.MemRead, 1);
      chk("ld_memwrite", bus.MemWrite, 0);
      chk("ld_memaddr", bus.MemAddress, 16'h0004);
      tick();
      bus.D_Req = 0;
      chk("ld_d_ack", bus.D_Ack, 1);
      chk("ld_c_ack", bus.C_Ack, 0);
      chk("ld_memread_resp", bus.MemRead, 0);
      chk("ld_d_rdata", bus.D_RData, 16'hBEEF);
      chk("ld_c_rdata_kept", bus.C_RData, 16'h0000);
      tick();
      chk("ld_ack_pulse", bus.D_Ack, 0);
      chk("ld_d_rdata_hold", bus.D_RData, 16'hBEEF);
   endtask

   task automatic test_round_robin();
      int last_ack;
      last_ack = 0;
      bus.C_Req = 1; bus.C_Write = 0; bus.C_Addr = 16'h0004;
      bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 16'h0004;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_memread", bus.MemRead, 1);
         tick();
         chk("rr_c_ack", bus.C_Ack, (i % 2 == 0) ? 1 : 0);
         chk("rr_d_ack", bus.D_Ack, (i % 2 == 1) ? 1 : 0);
         if (i > 0) chk("rr_ack_gap", cyc - last_ack, 3);
         last_ack = cyc;
         tick();
      end
      bus.C_Req = 0;
      bus.D_Req = 0;
      chk("rr_c_rdata", bus.C_RData, 16'hBEEF);
      chk("rr_d_rdata", bus.D_RData, 16'hBEEF);
   endtask

   task automatic test_reset_during_access();
      // Last grant was DMA, so a lone DMA request is used to get a DMA access.
      bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 16'h0004;
      tick();
      chk("ra_memread", bus.MemRead, 1);
      Reset = 1'b1;
      bus.D_Req = 0;
      tick();
      Reset = 1'b0;
      chk("ra_d_ack", bus.D_Ack, 0);
      chk("ra_c_ack", bus.C_Ack, 0);
      chk("ra_memread", bus.MemRead, 0);
      chk("ra_memwrite", bus.MemWrite, 0);
      chk("ra_memaddr", bus.MemAddress, 0);
      chk("ra_memwdata", bus.MemWriteData, 0);
      chk("ra_c_rdata", bus.C_RData, 0);
      chk("ra_d_rdata", bus.D_RData, 0);
      chk("ra_err", bus.Err, 0);
      tick();
      chk("ra_no_late_ack", bus.D_Ack, 0);
      // Tie after reset: CPU must win; 0x0088 masks to 0x0008.
      bus.C_Req = 1; bus.C_Write = 1; bus.C_Addr = 16'h0088; bus.C_WData = 16'hA55A;
      bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 16'h0004;
      tick();
      chk("ra_tie_cpu_wins", bus.MemWrite, 1);
      chk("ra_addr_masked", bus.MemAddress, 16'h0008);
      tick();
      bus.C_Req = 0;
      bus.D_Req = 0;
      chk("ra_tie_c_ack", bus.C_Ack, 1);
      chk("ra_tie_d_ack", bus.D_Ack, 0);
      chk("ra_mem8", mem[8], 8'hA5);
      tick();
   endtask

   task automatic test_misalign();
      // Put known bytes at 6/7 so an odd load at 5 reads {mem5, mem6}.
      bus.C_Req = 1; bus.C_Write = 1; bus.C_Addr = 16'h0006; bus.C_WData = 16'h1234;
      tick();
      tick();
      bus.C_Req = 0;
      chk("ma_store_ack", bus.C_Ack, 1);
      tick();
      bus.C_Req = 1; bus.C_Write = 0; bus.C_Addr = 16'h0005;
      tick();
`ifdef MISALIGN_CHECK_EN
      bus.C_Req = 0;
      chk("ma_c_ack", bus.C_Ack, 1);
      chk("ma_err", bus.Err, 1);
      chk("ma_no_memread", bus.MemRead, 0);
      chk("ma_rdata_kept", bus.C_RData, 16'h0000);
      tick();
      chk("ma_ack_pulse", bus.C_Ack, 0);
      chk("ma_err_pulse", bus.Err, 0);
      chk("ma_no_memread2", bus.MemRead, 0);
`else
      chk("ma_memread", bus.MemRead, 1);
      chk("ma_memaddr", bus.MemAddress, 16'h0005);
      tick();
      bus.C_Req = 0;
      chk("ma_c_ack", bus.C_Ack, 1);
      chk("ma_err", bus.Err, 0);
      chk("ma_rdata", bus.C_RData, 16'hEF12);
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_round_robin();
      test_reset_during_access();
      test_misalign();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
